// File: rtl/jtframe_rst_seq.sv
// Reset sequencer on the free-running board clock: supervises PLL lock, filters
// lock glitches and releases NCH reset domains in staggered order.
module jtframe_rst_seq #(
  parameter int         NCH        = 3,
  parameter int         LOCK_FILT  = 4,
  parameter int         LOCK_TO    = 4096,
  parameter int         PLL_HOLD   = 256,
  parameter int         HOLD       = 64,
  parameter int         STEP       = 16,
  parameter logic [7:0] DWNLD_MASK = 8'b0000_0110
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_locked,
  input  logic           rst_req,
  input  logic           dwnld_busy,
  output logic           pll_rst,
  output logic [NCH-1:0] rst_out,
  output logic [NCH-1:0] rst_out_n,
  output logic           ready,
  output logic [7:0]     lost_cnt
);

  localparam int STEP_MAX = STEP * (NCH - 1);
  localparam int LF_W     = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam int TO_W     = (LOCK_TO   > 1) ? $clog2(LOCK_TO)   : 1;
  localparam int PH_W     = (PLL_HOLD  > 1) ? $clog2(PLL_HOLD)  : 1;
  localparam int HD_W     = (HOLD      > 1) ? $clog2(HOLD)      : 1;
  localparam int ST_W     = (STEP_MAX  > 0) ? $clog2(STEP_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_PLL_RST,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  // 2-FF synchronisers for the asynchronous inputs
  logic r_lk_ff, r_lk_s;
  logic r_rq_ff, r_rq_s;
  logic r_dw_ff, r_dw_s;

  state_t            r_state,    w_state_nxt;
  logic [LF_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt,   w_to_cnt_nxt;
  logic [PH_W-1:0]   r_pll_cnt,  w_pll_cnt_nxt;
  logic [HD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [ST_W-1:0]   r_step,     w_step_nxt;

  logic [NCH-1:0]    w_hold_nxt;
  logic              w_ready_nxt;
  logic              w_lost;

  logic              r_pll_rst;
  logic [NCH-1:0]    r_rst_out;
  logic [NCH-1:0]    r_rst_out_n;
  logic              r_ready;
  logic [7:0]        r_lost_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_ff <= 1'b0;
      r_lk_s  <= 1'b0;
      r_rq_ff <= 1'b0;
      r_rq_s  <= 1'b0;
      r_dw_ff <= 1'b0;
      r_dw_s  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous
      // stage's old value, which is what gives a true two-stage synchroniser.
      r_lk_ff <= pll_locked;
      r_lk_s  <= r_lk_ff;
      r_rq_ff <= rst_req;
      r_rq_s  <= r_rq_ff;
      r_dw_ff <= dwnld_busy;
      r_dw_s  <= r_dw_ff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_WAIT_LOCK;
      r_lock_cnt <= '0;
      r_to_cnt   <= '0;
      r_pll_cnt  <= '0;
      r_hold_cnt <= '0;
      r_step     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_pll_cnt  <= w_pll_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_step     <= w_step_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch. Counters default to zero, so
    // each one is cleared whenever its own state is left or re-entered.
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = '0;
    w_to_cnt_nxt   = '0;
    w_pll_cnt_nxt  = '0;
    w_hold_cnt_nxt = '0;
    w_step_nxt     = '0;
    w_hold_nxt     = '1;
    w_ready_nxt    = 1'b0;
    w_lost         = 1'b0;

    case (r_state)
      S_WAIT_LOCK: begin
        w_lock_cnt_nxt = r_lk_s ? r_lock_cnt + LF_W'(1) : '0;
        w_to_cnt_nxt   = r_to_cnt + TO_W'(1);
        if (r_lk_s && r_lock_cnt == LF_W'(LOCK_FILT - 1)) begin
          w_state_nxt    = S_HOLD;
          w_lock_cnt_nxt = '0;
          w_to_cnt_nxt   = '0;
        end else if (r_to_cnt == TO_W'(LOCK_TO - 1)) begin
          w_state_nxt    = S_PLL_RST;
          w_lock_cnt_nxt = '0;
          w_to_cnt_nxt   = '0;
        end
      end

      S_PLL_RST: begin
        if (r_pll_cnt == PH_W'(PLL_HOLD - 1)) begin
          w_state_nxt = S_WAIT_LOCK;
        end else begin
          w_pll_cnt_nxt = r_pll_cnt + PH_W'(1);
        end
      end

      S_HOLD: begin
        if (!r_lk_s) begin
          w_state_nxt = S_PLL_RST;
          w_lost      = 1'b1;
        end else if (r_rq_s) begin
          w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt == HD_W'(HOLD - 1)) begin
          w_state_nxt = S_RELEASE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HD_W'(1);
        end
      end

      S_RELEASE: begin
        if (!r_lk_s) begin
          w_state_nxt = S_PLL_RST;
          w_lost      = 1'b1;
        end else if (r_rq_s) begin
          w_state_nxt = S_HOLD;
        end else begin
          // channel i stays held until the step counter has reached STEP*i
          for (int i = 0; i < NCH; i++) begin
            w_hold_nxt[i] = int'(r_step) < STEP * i;
          end
          if (int'(r_step) >= STEP_MAX) begin
            w_state_nxt = S_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_step_nxt = r_step + ST_W'(1);
          end
        end
      end

      S_RUN: begin
        if (!r_lk_s) begin
          w_state_nxt = S_PLL_RST;
          w_lost      = 1'b1;
        end else if (r_rq_s) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_hold_nxt  = '0;
          w_ready_nxt = 1'b1;
        end
      end

      default: w_state_nxt = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst   <= 1'b0;
      r_rst_out   <= '1;
      r_rst_out_n <= '0;
      r_ready     <= 1'b0;
      r_lost_cnt  <= '0;
    end else begin
      r_pll_rst   <= (w_state_nxt == S_PLL_RST);
      r_rst_out   <= w_hold_nxt | (DWNLD_MASK[NCH-1:0] & {NCH{r_dw_s}});
      r_rst_out_n <= ~(w_hold_nxt | (DWNLD_MASK[NCH-1:0] & {NCH{r_dw_s}}));
      r_ready     <= w_ready_nxt;
      if (w_lost && r_lost_cnt != 8'hFF) begin
        r_lost_cnt <= r_lost_cnt + 8'd1;
      end
    end
  end

  assign pll_rst   = r_pll_rst;
  assign rst_out   = r_rst_out;
  assign rst_out_n = r_rst_out_n;
  assign ready     = r_ready;
  assign lost_cnt  = r_lost_cnt;

endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Directed bench for jtframe_rst_seq: edge-exact release timing, lock loss,
// lock timeout, glitch filtering, download mask and reset requests.
module tb_jtframe_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       rst_req;
  logic       dwnld_busy;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic [2:0] rst_out_n;
  logic       ready;
  logic [7:0] lost_cnt;

  int checks = 0;
  int errors = 0;

  jtframe_rst_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .rst_req    (rst_req),
    .dwnld_busy (dwnld_busy),
    .pll_rst    (pll_rst),
    .rst_out    (rst_out),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .lost_cnt   (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release rst_n 1 ns after a rising edge; that edge is "edge 0" and a
  // following tick(k) lands just after edge k.
  task automatic do_reset(input logic lock);
    rst_n      = 1'b0;
    pll_locked = lock;
    rst_req    = 1'b0;
    dwnld_busy = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic bring_up();
    do_reset(1'b1);
    tick(103);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    rst_req    = 1'b1;
    dwnld_busy = 1'b1;
    tick(4);
    checks++;
    if ({pll_rst, rst_out, rst_out_n, ready, lost_cnt} !== {1'b0, 3'b111, 3'b000, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: pll_rst=%b rst_out=%b rst_out_n=%b ready=%b lost=%0d, expected 0 111 000 0 0",
               pll_rst, rst_out, rst_out_n, ready, lost_cnt);
    end
  endtask

  task automatic test_power_up();
    do_reset(1'b1);
    tick(70);
    checks++;
    if ({rst_out, ready} !== {3'b111, 1'b0}) begin
      errors++; $display("FAIL pwr_edge70: rst_out=%b ready=%b, expected 111 0", rst_out, ready);
    end
    tick(1);
    checks++;
    if ({rst_out, rst_out_n, ready} !== {3'b110, 3'b001, 1'b0}) begin
      errors++; $display("FAIL pwr_ch0_edge71: rst_out=%b rst_out_n=%b ready=%b, expected 110 001 0", rst_out, rst_out_n, ready);
    end
    tick(15);
    checks++;
    if (rst_out !== 3'b110) begin
      errors++; $display("FAIL pwr_edge86: rst_out=%b, expected 110", rst_out);
    end
    tick(1);
    checks++;
    if (rst_out !== 3'b100) begin
      errors++; $display("FAIL pwr_ch1_edge87: rst_out=%b, expected 100", rst_out);
    end
    tick(15);
    checks++;
    if ({rst_out, ready} !== {3'b100, 1'b0}) begin
      errors++; $display("FAIL pwr_edge102: rst_out=%b ready=%b, expected 100 0", rst_out, ready);
    end
    tick(1);
    checks++;
    if ({rst_out, rst_out_n, ready, pll_rst, lost_cnt} !== {3'b000, 3'b111, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL pwr_ch2_edge103: rst_out=%b rst_out_n=%b ready=%b pll_rst=%b lost=%0d, expected 000 111 1 0 0",
               rst_out, rst_out_n, ready, pll_rst, lost_cnt);
    end
  endtask

  task automatic test_lock_loss();
    bring_up();
    pll_locked = 1'b0;
    tick(2);
    checks++;
    if ({rst_out, ready, pll_rst} !== {3'b000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL loss_e2: rst_out=%b ready=%b pll_rst=%b, expected 000 1 0", rst_out, ready, pll_rst);
    end
    tick(1);
    checks++;
    if ({rst_out, ready, pll_rst, lost_cnt} !== {3'b111, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL loss_e3: rst_out=%b ready=%b pll_rst=%b lost=%0d, expected 111 0 1 1", rst_out, ready, pll_rst, lost_cnt);
    end
    tick(7);
    pll_locked = 1'b1;
    tick(248);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++; $display("FAIL loss_pll_last: pll_rst=%b, expected 1", pll_rst);
    end
    tick(1);
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++; $display("FAIL loss_pll_end: pll_rst=%b, expected 0", pll_rst);
    end
    tick(68);
    checks++;
    if (rst_out !== 3'b111) begin
      errors++; $display("FAIL loss_relock_hold: rst_out=%b, expected 111", rst_out);
    end
    tick(1);
    checks++;
    if (rst_out !== 3'b110) begin
      errors++; $display("FAIL loss_relock_ch0: rst_out=%b, expected 110", rst_out);
    end
    tick(32);
    checks++;
    if ({rst_out, ready, lost_cnt} !== {3'b000, 1'b1, 8'd1}) begin
      errors++; $display("FAIL loss_relock_run: rst_out=%b ready=%b lost=%0d, expected 000 1 1", rst_out, ready, lost_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lost_cnt, rst_out, ready} !== {8'd0, 3'b111, 1'b0}) begin
      errors++; $display("FAIL loss_async_rst: lost=%0d rst_out=%b ready=%b, expected 0 111 0", lost_cnt, rst_out, ready);
    end
  endtask

  task automatic test_no_lock();
    do_reset(1'b0);
    tick(4095);
    checks++;
    if ({pll_rst, rst_out} !== {1'b0, 3'b111}) begin
      errors++; $display("FAIL nolock_e4095: pll_rst=%b rst_out=%b, expected 0 111", pll_rst, rst_out);
    end
    tick(1);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++; $display("FAIL nolock_rise1: pll_rst=%b, expected 1", pll_rst);
    end
    tick(255);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++; $display("FAIL nolock_last1: pll_rst=%b, expected 1", pll_rst);
    end
    tick(1);
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++; $display("FAIL nolock_fall1: pll_rst=%b, expected 0", pll_rst);
    end
    tick(4095);
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++; $display("FAIL nolock_e8447: pll_rst=%b, expected 0", pll_rst);
    end
    tick(1);
    checks++;
    if ({pll_rst, rst_out, ready, lost_cnt} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL nolock_rise2: pll_rst=%b rst_out=%b ready=%b lost=%0d, expected 1 111 0 0", pll_rst, rst_out, ready, lost_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++; $display("FAIL nolock_async_rst: pll_rst=%b, expected 0", pll_rst);
    end
  endtask

  task automatic test_lock_glitch();
    int bad = 0;
    do_reset(1'b0);
    for (int k = 0; k < 600; k++) begin
      pll_locked = (k % 4) != 3;
      tick(1);
      if (rst_out !== 3'b111 || ready !== 1'b0 || pll_rst !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL glitch_held: %0d cycles left full reset, expected 0", bad);
    end
    checks++;
    if (lost_cnt !== 8'd0) begin
      errors++; $display("FAIL glitch_lost: lost=%0d, expected 0", lost_cnt);
    end
  endtask

  task automatic test_download();
    bring_up();
    dwnld_busy = 1'b1;
    tick(2);
    checks++;
    if ({rst_out, ready} !== {3'b000, 1'b1}) begin
      errors++; $display("FAIL dw_rise_e2: rst_out=%b ready=%b, expected 000 1", rst_out, ready);
    end
    tick(1);
    checks++;
    if ({rst_out, rst_out_n, ready} !== {3'b110, 3'b001, 1'b1}) begin
      errors++; $display("FAIL dw_rise_e3: rst_out=%b rst_out_n=%b ready=%b, expected 110 001 1", rst_out, rst_out_n, ready);
    end
    tick(250);
    checks++;
    if ({rst_out, ready} !== {3'b110, 1'b1}) begin
      errors++; $display("FAIL dw_mid: rst_out=%b ready=%b, expected 110 1", rst_out, ready);
    end
    tick(247);
    dwnld_busy = 1'b0;
    tick(2);
    checks++;
    if ({rst_out, ready} !== {3'b110, 1'b1}) begin
      errors++; $display("FAIL dw_fall_e2: rst_out=%b ready=%b, expected 110 1", rst_out, ready);
    end
    tick(1);
    checks++;
    if ({rst_out, ready} !== {3'b000, 1'b1}) begin
      errors++; $display("FAIL dw_fall_e3: rst_out=%b ready=%b, expected 000 1", rst_out, ready);
    end
  endtask

  task automatic test_req_pulse();
    bring_up();
    rst_req = 1'b1;
    tick(1);
    rst_req = 1'b0;
    tick(1);
    checks++;
    if ({rst_out, ready} !== {3'b000, 1'b1}) begin
      errors++; $display("FAIL req_e2: rst_out=%b ready=%b, expected 000 1", rst_out, ready);
    end
    tick(1);
    checks++;
    if ({rst_out, ready} !== {3'b111, 1'b0}) begin
      errors++; $display("FAIL req_e3: rst_out=%b ready=%b, expected 111 0", rst_out, ready);
    end
    tick(64);
    checks++;
    if (rst_out !== 3'b111) begin
      errors++; $display("FAIL req_hold_end: rst_out=%b, expected 111", rst_out);
    end
    tick(1);
    checks++;
    if (rst_out !== 3'b110) begin
      errors++; $display("FAIL req_ch0: rst_out=%b, expected 110", rst_out);
    end
    tick(15);
    checks++;
    if (rst_out !== 3'b110) begin
      errors++; $display("FAIL req_pre_ch1: rst_out=%b, expected 110", rst_out);
    end
    tick(1);
    checks++;
    if (rst_out !== 3'b100) begin
      errors++; $display("FAIL req_ch1: rst_out=%b, expected 100", rst_out);
    end
    tick(15);
    checks++;
    if ({rst_out, ready} !== {3'b100, 1'b0}) begin
      errors++; $display("FAIL req_pre_ch2: rst_out=%b ready=%b, expected 100 0", rst_out, ready);
    end
    tick(1);
    checks++;
    if ({rst_out, ready, lost_cnt} !== {3'b000, 1'b1, 8'd0}) begin
      errors++; $display("FAIL req_ch2: rst_out=%b ready=%b lost=%0d, expected 000 1 0", rst_out, ready, lost_cnt);
    end
  endtask

  task automatic test_simultaneous();
    bring_up();
    rst_req    = 1'b1;
    pll_locked = 1'b0;
    tick(3);
    checks++;
    if ({pll_rst, rst_out, ready, lost_cnt} !== {1'b1, 3'b111, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL simul_e3: pll_rst=%b rst_out=%b ready=%b lost=%0d, expected 1 111 0 1", pll_rst, rst_out, ready, lost_cnt);
    end
    rst_req    = 1'b0;
    pll_locked = 1'b1;
    tick(10);
    checks++;
    if ({pll_rst, lost_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL simul_stay: pll_rst=%b lost=%0d, expected 1 1", pll_rst, lost_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    tick(90);
    checks++;
    if (rst_out !== 3'b100) begin
      errors++; $display("FAIL async_pre: rst_out=%b, expected 100", rst_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rst_out, rst_out_n, ready, pll_rst} !== {3'b111, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_mid: rst_out=%b rst_out_n=%b ready=%b pll_rst=%b, expected 111 000 0 0", rst_out, rst_out_n, ready, pll_rst);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    rst_req    = 1'b0;
    dwnld_busy = 1'b0;
    test_reset();
    test_power_up();
    test_lock_loss();
    test_no_lock();
    test_lock_glitch();
    test_download();
    test_req_pulse();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
